// File: rtl/core_3do_pkg.sv
// Shared definitions for the 3DO core memory arbiter: FSM encoding and
// the fixed values driven onto the memory port and back to the masters.
package core_3do_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_XFER = 2'd1,
    ST_DMA_XFER = 2'd2
  } arb_state_t;

  // DMA transfers are always full 32-bit words.
  localparam logic [3:0]  DMA_SEL_ALL  = 4'hF;

  // Read data returned to a master whose transfer was aborted.
  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_arbiter_3do.sv
// Two-master arbiter for the shared DRAM/VRAM port. The MADAM DMA port has
// priority over the ZAP CPU Wishbone port, but after MAX_DMA_RUN back-to-back
// DMA grants with the CPU waiting, the next grant goes to the CPU. Every
// transfer is guarded by a timeout so a missing mem_ack cannot hang the core.
// All outputs come straight from flops.
module mem_arbiter_3do
  import core_3do_pkg::*;
#(
  parameter int MAX_DMA_RUN = 8,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_dat_w,
  input  logic [3:0]  cpu_sel,
  input  logic        cpu_we,
  input  logic        cpu_stb,
  output logic        cpu_ack,
  output logic [31:0] cpu_dat_r,
  input  logic [31:0] dma_adr,
  input  logic [31:0] dma_dat_w,
  input  logic        dma_rd,
  input  logic        dma_wr,
  output logic        dma_ack,
  output logic [31:0] dma_dat_r,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_dat_w,
  output logic [3:0]  mem_sel,
  output logic        mem_we,
  output logic        mem_stb,
  input  logic        mem_ack,
  input  logic [31:0] mem_dat_r,
  output logic        grant_dma,
  output logic        timeout_err
);

  localparam int              RUN_W   = $clog2(MAX_DMA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_d;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;

  logic [31:0] mem_adr_d, mem_dat_w_d, cpu_dat_r_d, dma_dat_r_d;
  logic [3:0]  mem_sel_d;
  logic        mem_we_d, mem_stb_d, cpu_ack_d, dma_ack_d;
  logic        grant_dma_d, timeout_err_d;

  logic cpu_req, dma_req, ack_busy, cpu_starved;
  logic pick_dma, pick_cpu, xfer_done, xfer_abort;

  // While an ack pulse is out, the acked master's request is still the old
  // one, so the arbiter defers every decision by that one cycle. Deferring the
  // other master too keeps priority and the DMA run count based only on real
  // requests, which is what lets a continuously requesting DMA reach its run
  // limit while the CPU waits.
  assign cpu_req     = cpu_stb;
  assign dma_req     = dma_rd | dma_wr;
  assign ack_busy    = cpu_ack | dma_ack;
  assign cpu_starved = cpu_req && (run_cnt == RUN_MAX);
  assign pick_dma    = (state == ST_IDLE) && !ack_busy && dma_req && !cpu_starved;
  assign pick_cpu    = (state == ST_IDLE) && !ack_busy && !pick_dma && cpu_req;
  assign xfer_done   = (state != ST_IDLE) && mem_ack;
  assign xfer_abort  = (state != ST_IDLE) && !mem_ack && (to_cnt == TO_LAST);

  // State register; reset returns to IDLE from anywhere, mid-transfer included.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: grant from IDLE, return to IDLE on completion or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (pick_dma)      state_nxt = ST_DMA_XFER;
        else if (pick_cpu) state_nxt = ST_CPU_XFER;
      end
      ST_CPU_XFER, ST_DMA_XFER: begin
        if (xfer_done || xfer_abort) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of every registered output and counter.
  always_comb begin
    mem_adr_d     = mem_adr;
    mem_dat_w_d   = mem_dat_w;
    mem_sel_d     = mem_sel;
    mem_we_d      = mem_we;
    mem_stb_d     = mem_stb;
    cpu_dat_r_d   = cpu_dat_r;
    dma_dat_r_d   = dma_dat_r;
    cpu_ack_d     = 1'b0;
    dma_ack_d     = 1'b0;
    timeout_err_d = 1'b0;
    run_cnt_d     = run_cnt;
    to_cnt_d      = to_cnt;
    grant_dma_d   = (state_nxt == ST_DMA_XFER);
    case (state)
      ST_IDLE: begin
        if (pick_dma) begin
          mem_adr_d   = dma_adr;
          mem_dat_w_d = dma_dat_w;
          mem_sel_d   = DMA_SEL_ALL;
          mem_we_d    = dma_wr;
          mem_stb_d   = 1'b1;
          to_cnt_d    = '0;
          run_cnt_d   = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end else if (pick_cpu) begin
          mem_adr_d   = cpu_adr;
          mem_dat_w_d = cpu_dat_w;
          mem_sel_d   = cpu_sel;
          mem_we_d    = cpu_we;
          mem_stb_d   = 1'b1;
          to_cnt_d    = '0;
          run_cnt_d   = '0;
        end else if (!ack_busy) begin
          run_cnt_d   = '0;
        end
      end
      ST_CPU_XFER, ST_DMA_XFER: begin
        if (xfer_done) begin
          mem_stb_d = 1'b0;
          if (state == ST_DMA_XFER) begin
            dma_ack_d   = 1'b1;
            dma_dat_r_d = mem_dat_r;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_dat_r_d = mem_dat_r;
          end
        end else if (xfer_abort) begin
          mem_stb_d     = 1'b0;
          timeout_err_d = 1'b1;
          if (state == ST_DMA_XFER) begin
            dma_ack_d   = 1'b1;
            dma_dat_r_d = TIMEOUT_DATA;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_dat_r_d = TIMEOUT_DATA;
          end
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      default: mem_stb_d = 1'b0;
    endcase
  end

  // Output and counter registers; everything clears on reset.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      mem_adr     <= '0;
      mem_dat_w   <= '0;
      mem_sel     <= '0;
      mem_we      <= 1'b0;
      mem_stb     <= 1'b0;
      cpu_ack     <= 1'b0;
      cpu_dat_r   <= '0;
      dma_ack     <= 1'b0;
      dma_dat_r   <= '0;
      grant_dma   <= 1'b0;
      timeout_err <= 1'b0;
      run_cnt     <= '0;
      to_cnt      <= '0;
    end else begin
      mem_adr     <= mem_adr_d;
      mem_dat_w   <= mem_dat_w_d;
      mem_sel     <= mem_sel_d;
      mem_we      <= mem_we_d;
      mem_stb     <= mem_stb_d;
      cpu_ack     <= cpu_ack_d;
      cpu_dat_r   <= cpu_dat_r_d;
      dma_ack     <= dma_ack_d;
      dma_dat_r   <= dma_dat_r_d;
      grant_dma   <= grant_dma_d;
      timeout_err <= timeout_err_d;
      run_cnt     <= run_cnt_d;
      to_cnt      <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_3do.sv
// Directed bench for mem_arbiter_3do. A behavioural memory returns
// address ^ KEY as read data; every expected master completion is queued
// when the request is driven and checked when an ack pulse appears.
module tb_mem_arbiter_3do;

  localparam logic [31:0] KEY = 32'h12345778;

  typedef struct {
    bit          isDma;
    logic [31:0] data;
    bit          timedOut;
  } exp_t;

  logic        sys_clk, reset;
  logic [31:0] cpu_adr, cpu_dat_w, cpu_dat_r;
  logic [3:0]  cpu_sel;
  logic        cpu_we, cpu_stb, cpu_ack;
  logic [31:0] dma_adr, dma_dat_w, dma_dat_r;
  logic        dma_rd, dma_wr, dma_ack;
  logic [31:0] mem_adr, mem_dat_w, mem_dat_r;
  logic [3:0]  mem_sel;
  logic        mem_we, mem_stb, mem_ack;
  logic        grant_dma, timeout_err;

  logic autoAck, manualAck;
  int   checks, errors;
  exp_t expQ[$];

  mem_arbiter_3do dut (
    .sys_clk(sys_clk), .reset(reset),
    .cpu_adr(cpu_adr), .cpu_dat_w(cpu_dat_w), .cpu_sel(cpu_sel), .cpu_we(cpu_we),
    .cpu_stb(cpu_stb), .cpu_ack(cpu_ack), .cpu_dat_r(cpu_dat_r),
    .dma_adr(dma_adr), .dma_dat_w(dma_dat_w), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_ack(dma_ack), .dma_dat_r(dma_dat_r),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_sel(mem_sel), .mem_we(mem_we),
    .mem_stb(mem_stb), .mem_ack(mem_ack), .mem_dat_r(mem_dat_r),
    .grant_dma(grant_dma), .timeout_err(timeout_err)
  );

  // Free-running system clock.
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Memory model: acks in the first strobe cycle when autoAck is set.
  assign mem_ack   = (autoAck & mem_stb) | manualAck;
  assign mem_dat_r = mem_adr ^ KEY;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit isDma, input logic [31:0] adr,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input bit we);
    if (isDma) begin
      dma_adr   = adr;
      dma_dat_w = dat;
      dma_wr    = we;
      dma_rd    = !we;
    end else begin
      cpu_adr   = adr;
      cpu_dat_w = dat;
      cpu_sel   = sel;
      cpu_we    = we;
      cpu_stb   = 1'b1;
    end
  endtask

  task automatic pushExp(input bit isDma, input logic [31:0] data, input bit timedOut);
    exp_t e;
    e.isDma    = isDma;
    e.data     = data;
    e.timedOut = timedOut;
    expQ.push_back(e);
  endtask

  task automatic waitStb(input string tag, input int budget);
    int n = 0;
    while (mem_stb !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'b0, mem_stb}, 32'h1);
  endtask

  task automatic waitAck(input string tag, input int budget);
    int n = 0;
    while ((cpu_ack | dma_ack) !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'b0, cpu_ack | dma_ack}, 32'h1);
  endtask

  // Scoreboard: every ack pulse must match the oldest queued completion.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!reset && (cpu_ack || dma_ack)) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_ack", {30'b0, dma_ack, cpu_ack}, 32'h0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_master", {30'b0, dma_ack, cpu_ack}, e.isDma ? 32'h2 : 32'h1);
        checkOutput("sb_data", e.isDma ? dma_dat_r : cpu_dat_r, e.data);
        checkOutput("sb_timeout", {31'b0, timeout_err}, {31'b0, e.timedOut});
      end
    end
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    reset = 1'b1; autoAck = 1'b1; manualAck = 1'b0;
    cpu_adr = '0; cpu_dat_w = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_stb = 1'b0;
    dma_adr = '0; dma_dat_w = '0; dma_rd = 1'b0; dma_wr = 1'b0;

    // Reset state
    idle(3);
    checkOutput("rst_stb", {31'b0, mem_stb}, 32'h0);
    checkOutput("rst_grant", {31'b0, grant_dma}, 32'h0);
    checkOutput("rst_acks", {30'b0, dma_ack, cpu_ack}, 32'h0);
    checkOutput("rst_adr", mem_adr, 32'h0);
    reset = 1'b0;
    idle(2);

    // 1: lone CPU read, ack two cycles after the request
    applyStimulus(0, 32'h0000_0100, 32'h0, 4'hF, 0);
    pushExp(0, 32'h1234_5678, 0);
    tick();
    checkOutput("t1_stb", {31'b0, mem_stb}, 32'h1);
    checkOutput("t1_adr", mem_adr, 32'h0000_0100);
    checkOutput("t1_early_ack", {31'b0, cpu_ack}, 32'h0);
    tick();
    checkOutput("t1_ack", {31'b0, cpu_ack}, 32'h1);
    checkOutput("t1_dat", cpu_dat_r, 32'h1234_5678);
    cpu_stb = 1'b0;
    idle(2);

    // 2: simultaneous requests, DMA first then CPU
    applyStimulus(0, 32'h200, 32'h0, 4'b1100, 0);
    applyStimulus(1, 32'h300, 32'h0, 4'hF, 0);
    pushExp(1, 32'h300 ^ KEY, 0);
    pushExp(0, 32'h200 ^ KEY, 0);
    waitStb("t2_stb_dma", 4);
    checkOutput("t2_grant_dma", {31'b0, grant_dma}, 32'h1);
    checkOutput("t2_sel_dma", {28'b0, mem_sel}, 32'hF);
    checkOutput("t2_adr_dma", mem_adr, 32'h300);
    waitAck("t2_ack_dma", 4);
    dma_rd = 1'b0;
    waitStb("t2_stb_cpu", 6);
    checkOutput("t2_grant_cpu", {31'b0, grant_dma}, 32'h0);
    checkOutput("t2_sel_cpu", {28'b0, mem_sel}, 32'hC);
    checkOutput("t2_adr_cpu", mem_adr, 32'h200);
    waitAck("t2_ack_cpu", 4);
    cpu_stb = 1'b0;
    idle(2);

    // 3: DMA held with CPU pending: 8 DMA, 1 CPU, then DMA again
    applyStimulus(0, 32'h400, 32'h0, 4'hF, 0);
    applyStimulus(1, 32'h500, 32'h0, 4'hF, 0);
    for (int i = 0; i < 10; i++) pushExp(i != 8, (i == 8) ? (32'h400 ^ KEY) : (32'h500 ^ KEY), 0);
    for (int i = 0; i < 10; i++) begin
      waitStb($sformatf("t3_stb%0d", i), 8);
      checkOutput($sformatf("t3_grant%0d", i), {31'b0, grant_dma}, {31'b0, i != 8});
      waitAck($sformatf("t3_ack%0d", i), 4);
      if (i == 8) cpu_stb = 1'b0;
      if (i == 9) dma_rd = 1'b0;
    end
    idle(2);

    // 4: no mem_ack, abort after 255 strobe cycles
    autoAck = 1'b0;
    applyStimulus(0, 32'h600, 32'h0, 4'hF, 0);
    pushExp(0, 32'h0, 1);
    waitStb("t4_stb", 4);
    n = 1;
    while (mem_stb === 1'b1 && n < 400) begin
      tick();
      if (mem_stb === 1'b1) n++;
    end
    checkOutput("t4_stb_cycles", n, 32'd255);
    checkOutput("t4_ack", {31'b0, cpu_ack}, 32'h1);
    checkOutput("t4_toerr", {31'b0, timeout_err}, 32'h1);
    checkOutput("t4_dat", cpu_dat_r, 32'h0);
    checkOutput("t4_dma_hold", dma_dat_r, 32'h500 ^ KEY);
    cpu_stb = 1'b0;
    idle(2);

    // 4b: mem_ack on the last strobe cycle completes normally
    applyStimulus(0, 32'h700, 32'h0, 4'hF, 0);
    pushExp(0, 32'h700 ^ KEY, 0);
    waitStb("t4b_stb", 4);
    idle(254);
    checkOutput("t4b_stb_c255", {31'b0, mem_stb}, 32'h1);
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
    checkOutput("t4b_ack", {31'b0, cpu_ack}, 32'h1);
    checkOutput("t4b_toerr", {31'b0, timeout_err}, 32'h0);
    cpu_stb = 1'b0;
    idle(2);

    // 5: CPU partial write held on the port until mem_ack
    applyStimulus(0, 32'h800, 32'hAABB_CCDD, 4'b0011, 1);
    pushExp(0, 32'h800 ^ KEY, 0);
    waitStb("t5_stb", 4);
    for (int k = 0; k < 3; k++) begin
      checkOutput("t5_we", {31'b0, mem_we}, 32'h1);
      checkOutput("t5_sel", {28'b0, mem_sel}, 32'h3);
      checkOutput("t5_dat_w", mem_dat_w, 32'hAABB_CCDD);
      checkOutput("t5_stb_held", {31'b0, mem_stb}, 32'h1);
      tick();
    end
    manualAck = 1'b1;
    tick();
    manualAck = 1'b0;
    checkOutput("t5_ack", {31'b0, cpu_ack}, 32'h1);
    checkOutput("t5_stb_drop", {31'b0, mem_stb}, 32'h0);
    cpu_stb = 1'b0;
    idle(2);

    // 6: async reset in the middle of a DMA write
    applyStimulus(1, 32'h900, 32'hCAFE_F00D, 4'hF, 1);
    waitStb("t6_stb_dma", 4);
    checkOutput("t6_grant_dma", {31'b0, grant_dma}, 32'h1);
    checkOutput("t6_we_dma", {31'b0, mem_we}, 32'h1);
    applyStimulus(0, 32'hA00, 32'h0, 4'b0101, 0);
    idle(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_stb", {31'b0, mem_stb}, 32'h0);
    checkOutput("t6_rst_grant", {31'b0, grant_dma}, 32'h0);
    checkOutput("t6_rst_we", {31'b0, mem_we}, 32'h0);
    checkOutput("t6_rst_adr", mem_adr, 32'h0);
    checkOutput("t6_rst_cpu_dat", cpu_dat_r, 32'h0);
    checkOutput("t6_rst_dma_dat", dma_dat_r, 32'h0);
    dma_wr  = 1'b0;
    autoAck = 1'b1;
    pushExp(0, 32'hA00 ^ KEY, 0);
    tick();
    reset = 1'b0;
    waitStb("t6_stb_cpu", 4);
    checkOutput("t6_grant_cpu", {31'b0, grant_dma}, 32'h0);
    checkOutput("t6_adr_cpu", mem_adr, 32'hA00);
    checkOutput("t6_sel_cpu", {28'b0, mem_sel}, 32'h5);
    waitAck("t6_ack_cpu", 4);
    cpu_stb = 1'b0;
    idle(3);

    checkOutput("sb_drained", expQ.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
